mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and burst sequencer in front of the byte-addressed main memory. It shares the memory between the instruction-fetch path (read-only) and the load/store path (read/write). It expands a multi-word read request (access_size 1/4/8/16 words) into consecutive single-word memory accesses. It returns each beat to the owning requester with valid/last strobes.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- START_ADDR, 32'h80020000, base of the memory window; passed through, not checked here

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- f_req  in  1  fetch request, held until f_gnt
- f_addr  in  32  fetch byte address; bits [1:0] ignored
- f_size  in  2  00=1, 01=4, 10=8, 11=16 words
- f_gnt  out  1  one-cycle grant pulse
- f_rdata  out  32  read beat
- f_rvalid  out  1  f_rdata valid
- f_rlast  out  1  final beat of burst
- d_req  in  1  load/store request, held until d_gnt
- d_rw  in  1  1=read, 0=write (memory convention)
- d_addr  in  32  byte address; bits [1:0] ignored
- d_size  in  2  as f_size; forced to 00 when d_rw=0
- d_wdata  in  32  write word
- d_gnt  out  1  one-cycle grant pulse
- d_rdata / d_rvalid / d_rlast  out  32/1/1  as fetch
- d_wdone  out  1  one-cycle pulse when a write has been accepted by memory
- mem_address  out  32  to memory
- mem_data_in  out  32  to memory
- mem_access_size  out  2  always 00 (single-word beats)
- mem_rw  out  1  to memory
- mem_enable  out  1  to memory
- mem_busy  in  1  memory busy; no access is accepted while high
- mem_data_out  in  32  memory read data, valid the cycle after the accepted read

## Operation
- States: IDLE, READ, WRITE, DRAIN.
- IDLE: at the clock edge where f_req|d_req is high, a 2-way round-robin picks the winner.
  - Tie goes to the port not granted last.
  - The last-grant pointer resets to data, so fetch wins the first tie.
  - Address (aligned to [1:0]=00), beat count N, rw and wdata are latched at that edge.
  - The winner's gnt is high for exactly the next cycle.
- READ:
  - Each cycle with issued<N and !mem_busy: mem_enable=1, mem_rw=1, mem_address=base+4*issued, issued increments.
  - A mem_busy cycle drives mem_enable=0 and does not advance.
  - When issued==N, go to DRAIN.
- DRAIN: wait until every issued beat has returned, then go to IDLE.
- Read return: mem_data_out is registered in the cycle after the issue cycle. rvalid/rdata appear on the owner's port the following cycle. rlast accompanies beat N.
- WRITE: mem_enable=1, mem_rw=0, mem_data_in=latched wdata.
  - Held while mem_busy is high.
  - On the first non-busy cycle the write is accepted; d_wdone pulses the next cycle; state goes to IDLE.
- Address arithmetic is 32-bit and wraps modulo 2^32 without error.
- A req still high after completion is a new request. No gnt is given for a request dropped before grant.
- Beats for a burst are always delivered in address order, only to the granted port.

## Timing
- Reset values: all gnt, rvalid, rlast, d_wdone, and mem_enable are 0. rdata, mem_address and mem_data_in are 0. mem_rw=1. State is IDLE.
- Reset mid-burst: next cycle all outputs are at reset values. Outstanding beats are discarded, and no rvalid follows.
- Read, no busy, grant cycle G:
  - Issues occur in G..G+N-1.
  - rvalid is high in G+2..G+N+1; rlast is at G+N+1.
  - The state is IDLE at G+N+2.
  - The next gnt is no earlier than G+N+3.
- Write, no busy: the access is in G, d_wdone is at G+1, IDLE at G+1, and the next gnt is no earlier than G+2.
- mem_busy during a read stretches issues. The return pipeline keeps draining regardless.

## Structure
- Package mem_ctrl_pkg holds:
  - state enum
  - access-size encodings and the beats(size) function: 1/4/8/16
  - START_ADDR
  - RD_LAT=1
- Sub-module rr_arbiter2: 2-request round-robin with pointer register, reset to data.

## Test plan
- Single fetch f_addr=0x80020000, f_size=00 -> one mem_enable at G, f_rvalid+f_rlast at G+2 with the memory word.
- Data burst d_addr=0x80020013, d_size=11 -> 16 issues at 0x80020010..0x8002004C step 4; 16 d_rvalid, d_rlast on the 16th only.
- f_req and d_req raised together twice -> fetch granted first, then data, then fetch.
- Write d_addr=0x80020100, d_wdata=0xDEADBEEF, mem_busy high 3 cycles -> mem_enable held 4 cycles, mem_rw=0, d_wdone one cycle after busy drops; a 1-word read back returns 0xDEADBEEF.
- 8-word fetch with mem_busy pulsed during issue 3 -> addresses still contiguous, 8 beats, no duplicates or gaps.
- reset asserted at G+3 of a 16-word burst -> no further rvalid; next request is granted normally after reset.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, access-size
// encodings, port identifiers and the read-return pipeline tag.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SIZE_1  = 2'b00,
    SIZE_4  = 2'b01,
    SIZE_8  = 2'b10,
    SIZE_16 = 2'b11
  } access_size_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_t;

  typedef struct packed {
    logic  valid;
    logic  last;
    port_t port;
  } beat_t;

  localparam logic [31:0] START_ADDR = 32'h8002_0000;
  localparam int          RD_LAT     = 1;

  function automatic logic [4:0] beats(input logic [1:0] size);
    case (access_size_t'(size))
      SIZE_1:  return 5'd1;
      SIZE_4:  return 5'd4;
      SIZE_8:  return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; the arbiter uses the slave
// view, the surrounding system (requesters plus memory) uses the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic [1:0]        f_size;
  logic              f_gnt;
  logic [DATA_W-1:0] f_rdata;
  logic              f_rvalid;
  logic              f_rlast;

  logic              d_req;
  logic              d_rw;
  logic [ADDR_W-1:0] d_addr;
  logic [1:0]        d_size;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  logic              d_rlast;
  logic              d_wdone;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [1:0]        mem_access_size;
  logic              mem_rw;
  logic              mem_enable;
  logic              mem_busy;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  f_req, f_addr, f_size,
    input  d_req, d_rw, d_addr, d_size, d_wdata,
    input  mem_busy, mem_data_out,
    output f_gnt, f_rdata, f_rvalid, f_rlast,
    output d_gnt, d_rdata, d_rvalid, d_rlast, d_wdone,
    output mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable
  );

  modport master (
    output f_req, f_addr, f_size,
    output d_req, d_rw, d_addr, d_size, d_wdata,
    output mem_busy, mem_data_out,
    input  f_gnt, f_rdata, f_rvalid, f_rlast,
    input  d_gnt, d_rdata, d_rvalid, d_rlast, d_wdone,
    input  mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin: on a tie the port not granted last wins. The pointer
// starts at data so fetch wins the first tie after reset.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,    // [0]=fetch, [1]=data
  input  logic       take,   // grant is consumed this cycle
  output logic [1:0] grant
);
  import mem_ctrl_pkg::*;

  port_t last;

  always_comb begin
    // NOTE: grant gets a default before any branch so no path leaves it unassigned (no inferred latch).
    grant = req;
    if (&req) grant = (last == PORT_DATA) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clock) begin
    if (reset)     last <= PORT_DATA;
    else if (take) last <= grant[1] ? PORT_DATA : PORT_FETCH;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and burst sequencer: shares single-word main memory between fetch and
// load/store, expands multi-word reads into beats returned to the owning port.
module mem_arbiter #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] START_ADDR = mem_ctrl_pkg::START_ADDR
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  import mem_ctrl_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        last_idx;
  logic [3:0]        issued;
  port_t             owner;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  beat_t             pipe [RD_LAT];

  logic [1:0] req;
  logic [1:0] grant;
  logic       take;
  logic       issue;
  logic       pipe_pending;
  logic       ret_f;
  logic       ret_d;

  // The window base is informational only; byte-offset bits of addresses are dropped.
  logic unused;
  assign unused = ^{START_ADDR, bus.f_addr[1:0], bus.d_addr[1:0]};

  assign req   = {bus.d_req, bus.f_req};
  assign take  = (state == S_IDLE) && (|req);
  assign issue = (state == S_READ) && !bus.mem_busy;

  rr_arbiter2 u_rr (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .take  (take),
    .grant (grant)
  );

  // A write holds the bus through busy; a read simply skips busy cycles.
  assign bus.mem_enable      = issue || (state == S_WRITE);
  assign bus.mem_rw          = rw_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_data_in     = wdata_q;
  assign bus.mem_access_size = SIZE_1;

  always_comb begin
    pipe_pending = 1'b0;
    for (int i = 0; i < RD_LAT; i++) pipe_pending = pipe_pending | pipe[i].valid;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      last_idx    <= '0;
      issued      <= '0;
      owner       <= PORT_DATA;
      rw_q        <= 1'b1;
      wdata_q     <= '0;
      bus.f_gnt   <= 1'b0;
      bus.d_gnt   <= 1'b0;
      bus.d_wdone <= 1'b0;
    end else begin
      bus.f_gnt   <= 1'b0;
      bus.d_gnt   <= 1'b0;
      bus.d_wdone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take) begin
            bus.f_gnt <= grant[0];
            bus.d_gnt <= grant[1];
            issued    <= '0;
            if (grant[1]) begin
              addr_q <= {bus.d_addr[ADDR_W-1:2], 2'b00};
              owner  <= PORT_DATA;
              if (bus.d_rw) begin
                rw_q     <= 1'b1;
                last_idx <= 4'(beats(bus.d_size) - 5'd1);
                state    <= S_READ;
              end else begin
                rw_q     <= 1'b0;
                wdata_q  <= bus.d_wdata;
                last_idx <= '0;
                state    <= S_WRITE;
              end
            end else begin
              addr_q   <= {bus.f_addr[ADDR_W-1:2], 2'b00};
              owner    <= PORT_FETCH;
              rw_q     <= 1'b1;
              last_idx <= 4'(beats(bus.f_size) - 5'd1);
              state    <= S_READ;
            end
          end
        end
        S_READ: begin
          if (!bus.mem_busy) begin
            addr_q <= addr_q + ADDR_W'(4);
            issued <= issued + 4'd1;
            if (issued == last_idx) state <= S_DRAIN;
          end
        end
        S_WRITE: begin
          if (!bus.mem_busy) begin
            bus.d_wdone <= 1'b1;
            rw_q        <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (!pipe_pending) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ret_f = pipe[RD_LAT-1].valid && (pipe[RD_LAT-1].port == PORT_FETCH);
  assign ret_d = pipe[RD_LAT-1].valid && (pipe[RD_LAT-1].port == PORT_DATA);

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the beat-tag pipe is reset, unlike a data store, so a reset discards beats in flight.
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      bus.f_rvalid <= 1'b0;
      bus.f_rlast  <= 1'b0;
      bus.f_rdata  <= '0;
      bus.d_rvalid <= 1'b0;
      bus.d_rlast  <= 1'b0;
      bus.d_rdata  <= '0;
    end else begin
      pipe[0] <= '{valid: issue, last: issue && (issued == last_idx), port: owner};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      bus.f_rvalid <= ret_f;
      bus.f_rlast  <= ret_f && pipe[RD_LAT-1].last;
      bus.d_rvalid <= ret_d;
      bus.d_rlast  <= ret_d && pipe[RD_LAT-1].last;
      if (ret_f) bus.f_rdata <= bus.mem_data_out;
      if (ret_d) bus.d_rdata <= bus.mem_data_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural memory, per-cycle event logs and
// hand-derived timing/address/data expectations.
module tb_mem_arbiter;

  localparam logic [31:0] BASE = 32'h8002_0000;

  typedef struct { int cyc; logic [31:0] addr; logic rw; logic [31:0] wdata; } en_t;
  typedef struct { int cyc; logic [31:0] data; logic last; } rbeat_t;
  typedef struct { int cyc; int port; } gnt_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  en_t    en_log[$];
  rbeat_t f_beats[$];
  rbeat_t d_beats[$];
  gnt_t   gnt_log[$];
  int     wd_log[$];

  logic [31:0] store [1024];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [9:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[11:2];
  endfunction

  // Memory: accepts when enabled and not busy, read data valid the next cycle.
  always @(posedge clk) begin
    bus.mem_data_out <= 32'hBAD0_BAD0;
    if (bus.mem_enable && !bus.mem_busy) begin
      if (bus.mem_rw) bus.mem_data_out <= store[widx(bus.mem_address)];
      else            store[widx(bus.mem_address)] <= bus.mem_data_in;
    end
  end

  always @(negedge clk) begin
    if (bus.mem_enable) en_log.push_back('{cyc, bus.mem_address, bus.mem_rw, bus.mem_data_in});
    if (bus.f_rvalid)   f_beats.push_back('{cyc, bus.f_rdata, bus.f_rlast});
    if (bus.d_rvalid)   d_beats.push_back('{cyc, bus.d_rdata, bus.d_rlast});
    if (bus.f_gnt)      gnt_log.push_back('{cyc, 0});
    if (bus.d_gnt)      gnt_log.push_back('{cyc, 1});
    if (bus.d_wdone)    wd_log.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic en_t en_at(input int i);
    en_t e = '{-1, 32'hFFFF_FFFF, 1'bx, 32'hFFFF_FFFF};
    if (i < en_log.size()) e = en_log[i];
    return e;
  endfunction

  function automatic rbeat_t fb_at(input int i);
    rbeat_t b = '{-1, 32'hFFFF_FFFF, 1'bx};
    if (i < f_beats.size()) b = f_beats[i];
    return b;
  endfunction

  function automatic rbeat_t db_at(input int i);
    rbeat_t b = '{-1, 32'hFFFF_FFFF, 1'bx};
    if (i < d_beats.size()) b = d_beats[i];
    return b;
  endfunction

  function automatic gnt_t g_at(input int i);
    gnt_t g = '{-1, -1};
    if (i < gnt_log.size()) g = gnt_log[i];
    return g;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    en_log.delete();
    f_beats.delete();
    d_beats.delete();
    gnt_log.delete();
    wd_log.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, {24'h0, bus.f_gnt, bus.d_gnt, bus.f_rvalid, bus.f_rlast,
                              bus.d_rvalid, bus.d_rlast, bus.d_wdone, bus.mem_enable}, 32'h0);
    check({tag, "_rdata"}, bus.f_rdata | bus.d_rdata, 32'h0);
    check({tag, "_mem_address"}, bus.mem_address, 32'h0);
    check({tag, "_mem_data_in"}, bus.mem_data_in, 32'h0);
    check({tag, "_mem_rw_size"}, {29'h0, bus.mem_rw, bus.mem_access_size}, 32'h4);
  endtask

  // Raises a request (called just after a rising edge), holds it until the grant
  // is seen, then drops it after that edge. g is the grant cycle.
  task automatic request(input int p, input logic rw, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata, output int g);
    if (p == 0) begin
      bus.f_addr = addr; bus.f_size = size; bus.f_req = 1'b1;
    end else begin
      bus.d_rw = rw; bus.d_addr = addr; bus.d_size = size; bus.d_wdata = wdata; bus.d_req = 1'b1;
    end
    g = -1;
    for (int k = 0; k < 64 && g < 0; k++) begin
      @(negedge clk);
      if ((p == 0 && bus.f_gnt) || (p == 1 && bus.d_gnt)) g = cyc;
    end
    check($sformatf("gnt_seen_p%0d", p), 32'(g >= 0), 32'd1);
    @(posedge clk);
    #1;
    if (p == 0) bus.f_req = 1'b0;
    else        bus.d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, g0, g1, ic;
    for (int i = 0; i < 1024; i++) store[i] = word_at(BASE + 32'(4 * i));
    rst = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = '0; bus.f_size = '0;
    bus.d_req = 1'b0; bus.d_rw = 1'b1; bus.d_addr = '0; bus.d_size = '0; bus.d_wdata = '0;
    bus.mem_busy = 1'b0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("por");

    // Single-word fetch
    clear_logs();
    request(0, 1'b1, BASE, 2'b00, 32'h0, g);
    step(6);
    check("f1_issue_count", en_log.size(), 1);
    check("f1_issue_cyc", en_at(0).cyc, g);
    check("f1_issue_addr", en_at(0).addr, BASE);
    check("f1_issue_rw", {31'h0, en_at(0).rw}, 1);
    check("f1_beat_count", f_beats.size(), 1);
    check("f1_beat_cyc", fb_at(0).cyc, g + 2);
    check("f1_beat_data", fb_at(0).data, word_at(BASE));
    check("f1_beat_last", {31'h0, fb_at(0).last}, 1);
    check("f1_no_d_beats", d_beats.size(), 0);

    // 16-word data burst from an unaligned address
    clear_logs();
    request(1, 1'b1, 32'h8002_0013, 2'b11, 32'h0, g);
    step(22);
    check("d16_issue_count", en_log.size(), 16);
    check("d16_beat_count", d_beats.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("d16_addr[%0d]", i), en_at(i).addr, 32'h8002_0010 + 32'(4 * i));
      check($sformatf("d16_icyc[%0d]", i), en_at(i).cyc, g + i);
      check($sformatf("d16_data[%0d]", i), db_at(i).data, word_at(32'h8002_0010 + 32'(4 * i)));
      check($sformatf("d16_bcyc[%0d]", i), db_at(i).cyc, g + 2 + i);
      check($sformatf("d16_last[%0d]", i), {31'h0, db_at(i).last}, 32'(i == 15));
    end
    check("d16_no_f_beats", f_beats.size(), 0);

    // Simultaneous requests, twice
    clear_logs();
    fork
      request(0, 1'b1, 32'h8002_0400, 2'b00, 32'h0, g0);
      request(1, 1'b1, 32'h8002_0404, 2'b00, 32'h0, g1);
    join
    step(6);
    fork
      request(0, 1'b1, 32'h8002_0400, 2'b00, 32'h0, g);
      request(1, 1'b1, 32'h8002_0404, 2'b00, 32'h0, g);
    join
    step(6);
    check("arb_gnt_count", gnt_log.size(), 4);
    check("arb_order0", g_at(0).port, 0);
    check("arb_order1", g_at(1).port, 1);
    check("arb_order2", g_at(2).port, 0);
    check("arb_order3", g_at(3).port, 1);
    check("arb_gap", g1 - g0, 4);
    check("arb_f_beats", f_beats.size(), 2);
    check("arb_d_beats", d_beats.size(), 2);
    check("arb_f_data", fb_at(1).data, word_at(32'h8002_0400));
    check("arb_d_data", db_at(1).data, word_at(32'h8002_0404));

    // Write held through three busy cycles; size field must be ignored for writes
    clear_logs();
    bus.mem_busy = 1'b1;
    request(1, 1'b0, 32'h8002_0100, 2'b11, 32'hDEAD_BEEF, g);
    step(2);
    bus.mem_busy = 1'b0;
    step(4);
    check("wr_enable_cycles", en_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_cyc[%0d]", i), en_at(i).cyc, g + i);
      check($sformatf("wr_bus[%0d]", i), {en_at(i).addr[30:0], en_at(i).rw},
            {31'(32'h8002_0100), 1'b0});
      check($sformatf("wr_data[%0d]", i), en_at(i).wdata, 32'hDEAD_BEEF);
    end
    check("wr_wdone_count", wd_log.size(), 1);
    check("wr_wdone_cyc", (wd_log.size() > 0) ? wd_log[0] : -1, g + 4);
    check("wr_no_beats", f_beats.size() + d_beats.size(), 0);
    clear_logs();
    request(1, 1'b1, 32'h8002_0100, 2'b00, 32'h0, g);
    step(5);
    check("rb_beat_count", d_beats.size(), 1);
    check("rb_data", db_at(0).data, 32'hDEAD_BEEF);

    // 8-word fetch with the third issue slot busy
    clear_logs();
    request(0, 1'b1, 32'h8002_0200, 2'b10, 32'h0, g);
    step(1);
    bus.mem_busy = 1'b1;
    step(1);
    bus.mem_busy = 1'b0;
    step(14);
    check("f8_issue_count", en_log.size(), 8);
    check("f8_beat_count", f_beats.size(), 8);
    for (int i = 0; i < 8; i++) begin
      ic = (i < 2) ? g + i : g + i + 1;
      check($sformatf("f8_addr[%0d]", i), en_at(i).addr, 32'h8002_0200 + 32'(4 * i));
      check($sformatf("f8_icyc[%0d]", i), en_at(i).cyc, ic);
      check($sformatf("f8_data[%0d]", i), fb_at(i).data, word_at(32'h8002_0200 + 32'(4 * i)));
      check($sformatf("f8_bcyc[%0d]", i), fb_at(i).cyc, ic + 2);
      check($sformatf("f8_last[%0d]", i), {31'h0, fb_at(i).last}, 32'(i == 7));
    end

    // Reset at G+3 of a 16-word fetch burst
    clear_logs();
    request(0, 1'b1, 32'h8002_0600, 2'b11, 32'h0, g);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_cyc", cyc, g + 4);
    check_reset_outputs("rst_mid");
    step(20);
    check("rst_issue_count", en_log.size(), 4);
    check("rst_f_beats", f_beats.size(), 2);
    check("rst_d_beats", d_beats.size(), 0);

    // After reset the pointer is back at data, so fetch wins the tie
    clear_logs();
    fork
      request(0, 1'b1, 32'h8002_0700, 2'b00, 32'h0, g0);
      request(1, 1'b1, 32'h8002_0704, 2'b00, 32'h0, g1);
    join
    step(6);
    check("post_rst_order0", g_at(0).port, 0);
    check("post_rst_order1", g_at(1).port, 1);
    check("post_rst_f_data", fb_at(0).data, word_at(32'h8002_0700));
    check("post_rst_d_data", db_at(0).data, word_at(32'h8002_0704));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
